// File: rtl/cpu_types_pkg.sv
// Shared CPU front-end types: PC source select, fetch sequencer states and
// the redirect record captured from EX/MEM.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    PC_NEXT = 2'd0,
    PC_BR   = 2'd1,
    PC_J    = 2'd2,
    PC_JR   = 2'd3
  } pcsrc_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    HALTED = 2'd2
  } fseq_state_t;

  typedef struct packed {
    pcsrc_t      src;
    logic        taken;
    logic [31:0] target;
  } redir_t;

  // A not-taken branch still selects PC_BR but falls through to +4.
  function automatic logic redir_effective(input redir_t r);
    return (r.src == PC_J) || (r.src == PC_JR) || ((r.src == PC_BR) && r.taken);
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating event counter for the fetch front end; holds at all-ones.
module fetch_perf_cnt #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC advance / redirect sequencer with stall-time redirect hold and sticky halt.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_sequencer
  import cpu_types_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter bit HALT_IREN = 1'b0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [1:0]  redir_src,
  input  logic        redir_taken,
  input  logic [31:0] redir_target,
  input  logic        halt,
  output logic        pcEN,
  output logic [1:0]  pc_src,
  output logic        branchmux,
  output logic [31:0] pc_target,
  output logic        iREN,
  output logic        flush_ifid,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redir_cnt
`endif
);

  fseq_state_t state, state_n;
  redir_t      pend, pend_n, redir_in, cur;
  pcsrc_t      src_o;
  logic        adv;

  assign redir_in = '{src: pcsrc_t'(redir_src), taken: redir_taken, target: redir_target};
  assign pc_src   = src_o;

  // NOTE: the pend registers are reset as well, so a held redirect never outlives nRST.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
      pend  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples its pre-edge value.
      state <= state_n;
      pend  <= pend_n;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    adv        = ihit & ~stall & (state != HALTED);
    state_n    = state;
    pend_n     = pend;
    cur        = (state == PEND) ? pend : redir_in;
    src_o      = PC_NEXT;
    branchmux  = 1'b0;
    pc_target  = '0;
    pcEN       = 1'b0;
    iREN       = 1'b1;
    flush_ifid = 1'b0;
    halted     = 1'b0;

    // Outputs sit at their reset values while nRST is held low.
    if (nRST) begin
      if (state == HALTED) begin
        iREN   = HALT_IREN;
        halted = 1'b1;
      end else if (halt) begin
        state_n = HALTED;
        pend_n  = '0;
      end else begin
        pcEN = adv;
        // The older pending redirect owns the outputs; new ones are duplicates.
        if ((state == PEND) || (redir_valid && adv)) begin
          src_o      = cur.src;
          branchmux  = cur.taken & (cur.src == PC_BR);
          pc_target  = cur.target;
          flush_ifid = adv & redir_effective(cur);
        end
        if ((state == RUN) && redir_valid && !adv) begin
          pend_n  = redir_in;
          state_n = PEND;
        end
        if ((state == PEND) && adv) begin
          pend_n  = '0;
          state_n = RUN;
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  fetch_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  ((state != HALTED) & ~adv),
    .cnt  (stall_cnt)
  );

  // flush_ifid is high exactly when an effective redirect is applied.
  fetch_perf_cnt #(.W(CNT_W)) u_redir_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (flush_ifid),
    .cnt  (redir_cnt)
  );
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, reset corner
// cases and a randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_fetch_sequencer;
  import cpu_types_pkg::*;

  localparam int CNT_W     = 32;
  localparam bit HALT_IREN = 1'b0;

  typedef struct packed {
    logic        ihit;
    logic        stall;
    logic        rv;
    logic [1:0]  src;
    logic        taken;
    logic [31:0] tgt;
    logic        halt;
  } ins_t;

  typedef struct packed {
    logic        pcen;
    logic [1:0]  src;
    logic        bm;
    logic [31:0] tgt;
    logic        flush;
    logic        iren;
    logic        halted;
  } outs_t;

  typedef struct packed {
    ins_t  in;
    outs_t exp;
  } vec_t;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, stall, redir_valid, redir_taken, halt;
  logic [1:0]  redir_src;
  logic [31:0] redir_target;
  logic        pcEN, branchmux, iREN, flush_ifid, halted;
  logic [1:0]  pc_src;
  logic [31:0] pc_target;
`ifdef FETCH_PERF_EN
  logic [CNT_W-1:0] stall_cnt, redir_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of held redirects, a halt flag, event counts.
  redir_t           pq[$];
  bit               m_halted;
  logic [CNT_W-1:0] m_stall, m_redir;

  always #5 CLK = ~CLK;

  fetch_sequencer #(.CNT_W(CNT_W), .HALT_IREN(HALT_IREN)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ihit         (ihit),
    .stall        (stall),
    .redir_valid  (redir_valid),
    .redir_src    (redir_src),
    .redir_taken  (redir_taken),
    .redir_target (redir_target),
    .halt         (halt),
    .pcEN         (pcEN),
    .pc_src       (pc_src),
    .branchmux    (branchmux),
    .pc_target    (pc_target),
    .iREN         (iREN),
    .flush_ifid   (flush_ifid),
    .halted       (halted)
`ifdef FETCH_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .redir_cnt    (redir_cnt)
`endif
  );

  function automatic ins_t mi(input logic ih, input logic st, input logic rv,
                              input logic [1:0] s, input logic tk,
                              input logic [31:0] t, input logic h);
    ins_t i;
    i.ihit = ih; i.stall = st; i.rv = rv; i.src = s; i.taken = tk; i.tgt = t; i.halt = h;
    return i;
  endfunction

  function automatic outs_t mo(input logic pe, input logic [1:0] s, input logic b,
                               input logic [31:0] t, input logic f, input logic ir,
                               input logic hl);
    outs_t o;
    o.pcen = pe; o.src = s; o.bm = b; o.tgt = t; o.flush = f; o.iren = ir; o.halted = hl;
    return o;
  endfunction

  function automatic outs_t model_out(input ins_t i);
    outs_t  o;
    redir_t r;
    bit     adv;
    o      = '0;
    o.iren = 1'b1;
    if (m_halted) begin
      o.iren   = HALT_IREN;
      o.halted = 1'b1;
      return o;
    end
    if (i.halt) return o;
    adv    = i.ihit && !i.stall;
    o.pcen = adv;
    if (pq.size() > 0 || (i.rv && adv)) begin
      if (pq.size() > 0) r = pq[0];
      else begin
        r.src = pcsrc_t'(i.src); r.taken = i.taken; r.target = i.tgt;
      end
      o.src   = r.src;
      o.bm    = r.taken && (r.src == PC_BR);
      o.tgt   = r.target;
      o.flush = adv && (r.src == PC_J || r.src == PC_JR || (r.src == PC_BR && r.taken));
    end
    return o;
  endfunction

  task automatic model_step(input ins_t i);
    outs_t  o;
    redir_t r;
    bit     adv;
    o   = model_out(i);
    adv = i.ihit && !i.stall && !m_halted;
    if (!m_halted && !adv && m_stall != '1) m_stall = m_stall + 1'b1;
    if (o.flush && m_redir != '1) m_redir = m_redir + 1'b1;
    if (m_halted) begin
    end else if (i.halt) begin
      m_halted = 1'b1;
      pq.delete();
    end else if (pq.size() > 0) begin
      if (adv) void'(pq.pop_front());
    end else if (i.rv && !adv) begin
      r.src = pcsrc_t'(i.src); r.taken = i.taken; r.target = i.tgt;
      pq.push_back(r);
    end
  endtask

  task automatic model_reset();
    pq.delete();
    m_halted = 1'b0;
    m_stall  = '0;
    m_redir  = '0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input outs_t e);
    check({tag, ".pcEN"},       32'(pcEN),       32'(e.pcen));
    check({tag, ".pc_src"},     32'(pc_src),     32'(e.src));
    check({tag, ".branchmux"},  32'(branchmux),  32'(e.bm));
    check({tag, ".pc_target"},  pc_target,       e.tgt);
    check({tag, ".flush_ifid"}, 32'(flush_ifid), 32'(e.flush));
    check({tag, ".iREN"},       32'(iREN),       32'(e.iren));
    check({tag, ".halted"},     32'(halted),     32'(e.halted));
`ifdef FETCH_PERF_EN
    check({tag, ".stall_cnt"},  stall_cnt,       m_stall);
    check({tag, ".redir_cnt"},  redir_cnt,       m_redir);
`endif
  endtask

  task automatic drive_in(input ins_t i);
    ihit = i.ihit; stall = i.stall; redir_valid = i.rv; redir_src = i.src;
    redir_taken = i.taken; redir_target = i.tgt; halt = i.halt;
  endtask

  task automatic run_cycle(input ins_t i, input outs_t e, input string tag);
    @(negedge CLK);
    drive_in(i);
    #1;
    check_outs(tag, e);
    @(posedge CLK);
    model_step(i);
  endtask

  task automatic release_reset();
    @(negedge CLK);
    nRST = 1'b1;
    drive_in(mi(0, 0, 0, 0, 0, 0, 0));
    @(posedge CLK);
    model_step(mi(0, 0, 0, 0, 0, 0, 0));
  endtask

  // Reset asserted with an advancing redirect on the inputs: outputs must still read as reset.
  task automatic do_reset(input string tag);
    @(negedge CLK);
    nRST = 1'b0;
    drive_in(mi(1, 0, 1, 2, 1, 32'hDEAD_BEEC, 0));
    #1;
    model_reset();
    check_outs(tag, mo(0, 0, 0, 0, 0, 1, 0));
    @(negedge CLK);
    release_reset();
  endtask

  vec_t  tbl[$];
  ins_t  ri;
  outs_t re;
  int    hcnt;

  initial begin
    nRST = 1'b0;
    drive_in(mi(0, 0, 0, 0, 0, 0, 0));
    model_reset();

    for (int k = 0; k < 4; k++) tbl.push_back('{mi(1,0,0,0,0,0,0), mo(1,0,0,0,0,1,0)});
    tbl.push_back('{mi(1,0,1,2,0,32'h100,0), mo(1,2,0,32'h100,1,1,0)});
    tbl.push_back('{mi(0,0,1,1,1,32'h40,0),  mo(0,0,0,0,0,1,0)});
    tbl.push_back('{mi(0,0,0,0,0,0,0),       mo(0,1,1,32'h40,0,1,0)});
    tbl.push_back('{mi(0,0,0,0,0,0,0),       mo(0,1,1,32'h40,0,1,0)});
    tbl.push_back('{mi(1,0,0,0,0,0,0),       mo(1,1,1,32'h40,1,1,0)});
    tbl.push_back('{mi(1,0,0,0,0,0,0),       mo(1,0,0,0,0,1,0)});
    tbl.push_back('{mi(1,0,1,1,0,32'h80,0),  mo(1,1,0,32'h80,0,1,0)});
    tbl.push_back('{mi(1,1,0,0,0,0,0),       mo(0,0,0,0,0,1,0)});
    tbl.push_back('{mi(1,1,1,2,0,32'h200,0), mo(0,0,0,0,0,1,0)});
    tbl.push_back('{mi(1,1,1,3,0,32'h300,0), mo(0,2,0,32'h200,0,1,0)});
    tbl.push_back('{mi(1,0,1,3,0,32'h300,0), mo(1,2,0,32'h200,1,1,0)});
    tbl.push_back('{mi(1,0,0,0,0,0,0),       mo(1,0,0,0,0,1,0)});
    tbl.push_back('{mi(1,0,1,3,0,32'h1234,0),mo(1,3,0,32'h1234,1,1,0)});
    tbl.push_back('{mi(1,0,1,3,0,32'h500,1), mo(0,0,0,0,0,1,0)});
    for (int k = 0; k < 10; k++)
      tbl.push_back('{mi(k[0], k[1], 1, 2'(k % 3 + 1), k[2], 32'(k * 16), logic'(k % 3 == 0)),
                      mo(0,0,0,0,0,HALT_IREN,1)});

    do_reset("reset0");
    for (int k = 0; k < tbl.size(); k++)
      run_cycle(tbl[k].in, tbl[k].exp, $sformatf("vec%0d", k));

    // Asynchronous reset while a redirect is held: it must be dropped.
    do_reset("reset1");
    run_cycle(mi(0,0,1,2,0,32'h300,0), mo(0,0,0,0,0,1,0), "pend_set");
    @(negedge CLK);
    drive_in(mi(0,0,0,0,0,0,0));
    #1;
    check_outs("pend_hold", mo(0,2,0,32'h300,0,1,0));
    #2;
    nRST = 1'b0;
    #1;
    model_reset();
    check_outs("async_rst", mo(0,0,0,0,0,1,0));
    @(negedge CLK);
    release_reset();
    run_cycle(mi(1,0,0,0,0,0,0), mo(1,0,0,0,0,1,0), "post_rst");

    // Randomized traffic against the reference model.
    do_reset("reset2");
    hcnt = 0;
    for (int n = 0; n < 3000; n++) begin
      if (m_halted) begin
        hcnt++;
        if (hcnt > 12) begin
          do_reset("reset_rand");
          hcnt = 0;
        end
      end
      ri.ihit  = ($urandom_range(0, 9) < 7);
      ri.stall = ($urandom_range(0, 9) < 2);
      ri.rv    = ($urandom_range(0, 9) < 3);
      ri.src   = 2'($urandom_range(1, 3));
      ri.taken = 1'($urandom_range(0, 1));
      ri.tgt   = $urandom;
      ri.halt  = ($urandom_range(0, 199) == 0);
      re = model_out(ri);
      run_cycle(ri, re, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
